// File: rtl/cipo_pkg.sv
// Shared constants and FSM state type for the CIPO oversampling front end.
package cipo_pkg;

  localparam int CIPO4X_WIDTH    = 74;
  localparam int SAMPLES_PER_BIT = 4;
  localparam int CIPO_BITS       = 16;
  localparam int MAX_PHASE       = 11;

  typedef enum logic {
    IDLE,
    CAPTURE
  } captureState_t;

endpackage

// File: rtl/cipo_sync.sv
// Generic flop-chain synchronizer for asynchronous headstage inputs.
module cipo_sync #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic async_i,
  output logic sync_o
);

  logic [STAGES-1:0] chain_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], async_i};
    end
  end

  assign sync_o = chain_q[STAGES-1];

endmodule

// File: rtl/cipo_oversample_capture.sv
// Captures a frame's worth of 4x-oversampled CIPO samples and presents them
// to the phase selector as one held window with a single-cycle valid strobe.
module cipo_oversample_capture
  import cipo_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int WINDOW      = CIPO4X_WIDTH
) (
  input  logic              dataclk,
  input  logic              reset,
  input  logic              cipo_in,
  input  logic              frame_start,
  input  logic              overrun_clr,
  output logic [WINDOW-1:0] CIPO4x,
  output logic              cipo4x_valid,
  output logic              busy,
  output logic              overrun
);

  localparam int CNT_W = $clog2(WINDOW);
  localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'(WINDOW - 1);

  logic              cipoSync;
  captureState_t     state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WINDOW-1:0] shreg_q, shreg_d;
  logic [WINDOW-1:0] window_q, window_d;
  logic              valid_q, valid_d;
  logic              overrun_q, overrun_d;

  cipo_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clock   (dataclk),
    .reset   (reset),
    .async_i (cipo_in),
    .sync_o  (cipoSync)
  );

  always_ff @(posedge dataclk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shreg_q   <= '0;
      window_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      window_q  <= window_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  // A strobe during capture restarts the window; the last sample bypasses
  // the shift register so the window publishes on the same edge.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    window_d  = window_q;
    valid_d   = 1'b0;
    overrun_d = overrun_q;
    if (overrun_clr) begin
      overrun_d = 1'b0;
    end
    case (state_q)
      IDLE: begin
        if (frame_start) begin
          state_d = CAPTURE;
          cnt_d   = '0;
        end
      end
      CAPTURE: begin
        if (frame_start) begin
          cnt_d     = '0;
          overrun_d = 1'b1;
        end else begin
          shreg_d[cnt_q] = cipoSync;
          if (cnt_q == LAST_SAMPLE) begin
            window_d = shreg_d;
            valid_d  = 1'b1;
            state_d  = IDLE;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign CIPO4x       = window_q;
  assign cipo4x_valid = valid_q;
  assign busy         = (state_q == CAPTURE);
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_cipo_oversample_capture.sv
// Directed self-checking bench: per-step stimulus tables replayed against the
// capture block, with outputs logged each cycle and compared afterwards.
module tb_cipo_oversample_capture;

  localparam int SYNC_STAGES = 2;
  localparam int MAXSTEPS    = 300;
  localparam logic [73:0] ALT_WIN  = 74'h2_AAAA_AAAA_AAAA_AAAA_AA;
  localparam logic [73:0] WORD_WIN = 74'h0_FF00_00FF_F0F0_0F0F;
  localparam logic [15:0] WORD     = 16'hA5C3;

  logic        dataclk = 1'b0;
  logic        reset;
  logic        cipo_in;
  logic        frame_start;
  logic        overrun_clr;
  logic [73:0] CIPO4x;
  logic        cipo4x_valid;
  logic        busy;
  logic        overrun;

  logic        inArr   [MAXSTEPS];
  logic        fsArr   [MAXSTEPS];
  logic        clrArr  [MAXSTEPS];
  logic        rstArr  [MAXSTEPS];
  logic        validLog[MAXSTEPS];
  logic        busyLog [MAXSTEPS];
  logic        ovLog   [MAXSTEPS];
  logic [73:0] winLog  [MAXSTEPS];

  int totalChecks = 0;
  int badChecks   = 0;

  logic [73:0] altPat, onesPat, zeroPat, word0Pat, word5Pat;

  cipo_oversample_capture #(
    .SYNC_STAGES (SYNC_STAGES),
    .WINDOW      (74)
  ) dut (
    .dataclk      (dataclk),
    .reset        (reset),
    .cipo_in      (cipo_in),
    .frame_start  (frame_start),
    .overrun_clr  (overrun_clr),
    .CIPO4x       (CIPO4x),
    .cipo4x_valid (cipo4x_valid),
    .busy         (busy),
    .overrun      (overrun)
  );

  always #5 dataclk = ~dataclk;

  task automatic checkOutput(input string tag, input logic [73:0] got, input logic [73:0] exp);
    totalChecks++;
    if (got !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic clearSchedule();
    for (int i = 0; i < MAXSTEPS; i++) begin
      inArr[i]  = 1'b0;
      fsArr[i]  = 1'b0;
      clrArr[i] = 1'b0;
      rstArr[i] = 1'b0;
    end
  endtask

  // Sample n must be on cipo_in SYNC_STAGES-1 edges before edge k+1+n.
  task automatic placeFrame(input int tFs, input logic [73:0] pat);
    fsArr[tFs] = 1'b1;
    for (int n = 0; n < 74; n++) begin
      int idx;
      idx = tFs + n + 1 - SYNC_STAGES;
      if (idx >= 0 && idx < MAXSTEPS) inArr[idx] = pat[n];
    end
  endtask

  // Step t logs outputs after edge t-1, then drives inputs for edge t.
  task automatic applyStimulus(input int nSteps);
    for (int t = 0; t < nSteps; t++) begin
      @(negedge dataclk);
      validLog[t]  = cipo4x_valid;
      busyLog[t]   = busy;
      ovLog[t]     = overrun;
      winLog[t]    = CIPO4x;
      cipo_in      = inArr[t];
      frame_start  = fsArr[t];
      overrun_clr  = clrArr[t];
      reset        = rstArr[t];
    end
  endtask

  function automatic int countValid(input int nSteps);
    int c = 0;
    for (int t = 0; t < nSteps; t++) if (validLog[t]) c++;
    return c;
  endfunction

  function automatic int countBusy(input int nSteps);
    int c = 0;
    for (int t = 0; t < nSteps; t++) if (busyLog[t]) c++;
    return c;
  endfunction

  function automatic logic [73:0] makeWordPat(input int off);
    logic [73:0] p = '0;
    for (int n = off; n < off + 64; n++) p[n] = WORD[15 - (n - off) / 4];
    return p;
  endfunction

  function automatic logic [15:0] extractWord(input logic [73:0] win, input int off);
    logic [15:0] w;
    for (int j = 0; j < 16; j++) w[15 - j] = win[off + 4 * j];
    return w;
  endfunction

  initial begin
    for (int n = 0; n < 74; n++) altPat[n] = (n % 2 == 1);
    onesPat  = '1;
    zeroPat  = '0;
    word0Pat = makeWordPat(0);
    word5Pat = makeWordPat(5);

    reset       = 1'b1;
    cipo_in     = 1'b0;
    frame_start = 1'b0;
    overrun_clr = 1'b0;
    repeat (3) @(negedge dataclk);
    checkOutput("rst_window",  CIPO4x, 74'd0);
    checkOutput("rst_valid",   74'(cipo4x_valid), 74'd0);
    checkOutput("rst_busy",    74'(busy), 74'd0);
    checkOutput("rst_overrun", 74'(overrun), 74'd0);
    reset = 1'b0;

    // Idle with cipo_in high and no strobe
    clearSchedule();
    for (int t = 0; t < 200; t++) inArr[t] = 1'b1;
    applyStimulus(200);
    checkOutput("idle_valid_cnt", 74'(countValid(200)), 74'd0);
    checkOutput("idle_busy_cnt",  74'(countBusy(200)), 74'd0);
    checkOutput("idle_window",    winLog[199], 74'd0);
    checkOutput("idle_overrun",   74'(ovLog[199]), 74'd0);

    // Alternating pattern capture
    clearSchedule();
    placeFrame(5, altPat);
    applyStimulus(90);
    checkOutput("alt_valid_at74", 74'(validLog[80]), 74'd1);
    checkOutput("alt_valid_cnt",  74'(countValid(90)), 74'd1);
    checkOutput("alt_window",     winLog[80], ALT_WIN);
    checkOutput("alt_busy_cnt",   74'(countBusy(90)), 74'd74);
    checkOutput("alt_busy_end",   74'(busyLog[80]), 74'd0);
    checkOutput("alt_hold",       winLog[89], ALT_WIN);

    // Word alignment at sample offsets 0 and 5
    clearSchedule();
    placeFrame(5, word0Pat);
    applyStimulus(90);
    checkOutput("word0_valid",  74'(validLog[80]), 74'd1);
    checkOutput("word0_extract", 74'(extractWord(winLog[80], 0)), 74'(WORD));
    checkOutput("word0_window", winLog[80], WORD_WIN);
    clearSchedule();
    placeFrame(5, word5Pat);
    applyStimulus(90);
    checkOutput("word5_extract", 74'(extractWord(winLog[80], 5)), 74'(WORD));
    checkOutput("word5_window",  winLog[80], WORD_WIN << 5);

    // Back-to-back: second strobe in the valid cycle
    clearSchedule();
    placeFrame(5, altPat);
    placeFrame(80, onesPat);
    applyStimulus(160);
    checkOutput("b2b_valid1",    74'(validLog[80]), 74'd1);
    checkOutput("b2b_window1",   winLog[80], ALT_WIN);
    checkOutput("b2b_busy_next", 74'(busyLog[81]), 74'd1);
    checkOutput("b2b_valid2",    74'(validLog[155]), 74'd1);
    checkOutput("b2b_window2",   winLog[155], onesPat);
    checkOutput("b2b_valid_cnt", 74'(countValid(160)), 74'd2);
    checkOutput("b2b_overrun",   74'(ovLog[156]), 74'd0);

    // Overrun at sample 40, then clear-vs-set priority
    clearSchedule();
    placeFrame(5, altPat);
    placeFrame(46, zeroPat);
    placeFrame(130, zeroPat);
    placeFrame(140, onesPat);
    clrArr[140] = 1'b1;
    clrArr[150] = 1'b1;
    applyStimulus(220);
    checkOutput("ovr_before",      74'(ovLog[46]), 74'd0);
    checkOutput("ovr_set",         74'(ovLog[47]), 74'd1);
    checkOutput("ovr_no_valid",    74'(validLog[80]), 74'd0);
    checkOutput("ovr_win_held",    winLog[81], onesPat);
    checkOutput("ovr_valid2",      74'(validLog[121]), 74'd1);
    checkOutput("ovr_window2",     winLog[121], zeroPat);
    checkOutput("ovr_normal_start", 74'(ovLog[131]), 74'd1);
    checkOutput("ovr_clr_vs_set",  74'(ovLog[141]), 74'd1);
    checkOutput("ovr_clr",         74'(ovLog[151]), 74'd0);
    checkOutput("ovr_valid4",      74'(validLog[215]), 74'd1);
    checkOutput("ovr_valid_cnt",   74'(countValid(220)), 74'd2);

    // Reset mid-capture, then a clean frame
    clearSchedule();
    placeFrame(5, altPat);
    placeFrame(20, altPat);
    for (int t = 36; t < 40; t++) rstArr[t] = 1'b1;
    placeFrame(45, word0Pat);
    applyStimulus(130);
    checkOutput("mrst_ovr_pre",   74'(ovLog[36]), 74'd1);
    checkOutput("mrst_busy",      74'(busyLog[37]), 74'd0);
    checkOutput("mrst_overrun",   74'(ovLog[37]), 74'd0);
    checkOutput("mrst_window",    winLog[37], 74'd0);
    checkOutput("mrst_valid_cnt", 74'(countValid(130)), 74'd1);
    checkOutput("mrst_valid",     74'(validLog[120]), 74'd1);
    checkOutput("mrst_window2",   winLog[120], WORD_WIN);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
